// File: rtl/req_scheduler_pkg.sv
// Shared definitions for the request scheduler: FSM states and width constants.
package req_scheduler_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    localparam int REQ_ID_WIDTH_DEFAULT = 32;
    localparam int OUTSTANDING_W        = 4;
    localparam int GRANT_IDX_W          = 3;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the requester just above last_idx has the
// highest priority, searching upward and wrapping back to index 0.
module rr_picker
    import req_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]     req,
    input  logic [GRANT_IDX_W-1:0] last_idx,
    output logic [NUM_REQ-1:0]     grant,
    output logic [GRANT_IDX_W-1:0] grant_idx,
    output logic                   grant_valid
);

    // Two passes: first the indices above last_idx, then the wrapped-around ones.
    always_comb begin
        grant       = '0;
        grant_idx   = last_idx;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i] && (GRANT_IDX_W'(i) > last_idx)) begin
                grant[i]    = 1'b1;
                grant_idx   = GRANT_IDX_W'(i);
                grant_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req[i] && (GRANT_IDX_W'(i) <= last_idx)) begin
                grant[i]    = 1'b1;
                grant_idx   = GRANT_IDX_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_scheduler.sv
// Request scheduler: picks one requester ID at a time round-robin, offers it to
// the row-request consumer, and tracks packets in flight via the TX footer taps.
module req_scheduler
    import req_scheduler_pkg::*;
#(
    parameter int REQ_ID_WIDTH    = REQ_ID_WIDTH_DEFAULT,
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ENABLE,
    input  logic [NUM_REQ*REQ_ID_WIDTH-1:0] REQ_ID_IN,
    input  logic [NUM_REQ-1:0]              REQ_VALID_IN,
    output logic [NUM_REQ-1:0]              REQ_READY_OUT,
    output logic [REQ_ID_WIDTH-1:0]         REQ_ID_OUT,
    output logic                            REQ_ID_VALID,
    input  logic                            READY_FOR_REQ,
    input  logic                            TX_TVALID,
    input  logic                            TX_TREADY,
    input  logic                            TX_TLAST,
    output logic [OUTSTANDING_W-1:0]        OUTSTANDING,
    output logic [GRANT_IDX_W-1:0]          LAST_GRANT,
    output logic [31:0]                     PKT_COUNT,
    output logic                            ERR_UNDERFLOW,
    output logic                            IDLE
);

    state_t                   state;
    state_t                   state_next;
    logic [REQ_ID_WIDTH-1:0]  req_id_q;
    logic [REQ_ID_WIDTH-1:0]  sel_id;
    logic [GRANT_IDX_W-1:0]   last_grant_q;
    logic [GRANT_IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0]       pick_onehot;
    logic                     pick_valid;
    logic                     can_issue;
    logic                     grant_hs;
    logic                     issue_hs;
    logic                     footer;
    logic [OUTSTANDING_W-1:0] outstanding_q;
    logic [31:0]              pkt_count_q;
    logic                     err_q;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req        (REQ_VALID_IN),
        .last_idx   (last_grant_q),
        .grant      (pick_onehot),
        .grant_idx  (pick_idx),
        .grant_valid(pick_valid)
    );

    assign can_issue     = ENABLE & (state == S_IDLE) &
                           (outstanding_q < OUTSTANDING_W'(MAX_OUTSTANDING));
    assign grant_hs      = can_issue & pick_valid & ~reset;
    assign issue_hs      = (state == S_OFFER) & READY_FOR_REQ;
    assign footer        = TX_TVALID & TX_TREADY & TX_TLAST;
    assign REQ_READY_OUT = grant_hs ? pick_onehot : '0;

    // Select the winning requester's ID slice using the one-hot grant.
    always_comb begin
        sel_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                sel_id = REQ_ID_IN[i*REQ_ID_WIDTH +: REQ_ID_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state: grant moves to OFFER, consumer handshake returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_hs) state_next = S_OFFER;
            S_OFFER: if (READY_FOR_REQ) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Capture the granted ID and remember who won for the next rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_id_q     <= '0;
            last_grant_q <= GRANT_IDX_W'(NUM_REQ - 1);
        end else if (grant_hs) begin
            req_id_q     <= sel_id;
            last_grant_q <= pick_idx;
        end
    end

    // In-flight packet accounting; an issue and a footer together cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_q <= '0;
            pkt_count_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            case ({issue_hs, footer})
                2'b10: outstanding_q <= outstanding_q + 1'b1;
                2'b01: begin
                    if (outstanding_q == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        outstanding_q <= outstanding_q - 1'b1;
                    end
                end
                default: outstanding_q <= outstanding_q;
            endcase
            if (footer) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign REQ_ID_OUT    = req_id_q;
    assign REQ_ID_VALID  = (state == S_OFFER);
    assign OUTSTANDING   = outstanding_q;
    assign LAST_GRANT    = last_grant_q;
    assign PKT_COUNT     = pkt_count_q;
    assign ERR_UNDERFLOW = err_q;
    assign IDLE          = (state == S_IDLE) & (outstanding_q == '0);

endmodule

// File: tb/tb_req_scheduler.sv
// Self-checking bench for req_scheduler: directed scenarios plus randomized
// traffic compared against a behavioural model of the scheduling rules.
module tb_req_scheduler;

    localparam int W    = 32;
    localparam int N    = 4;
    localparam int MAXO = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N*W-1:0] req_id_in;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   ready_out;
    logic [W-1:0]   id_out;
    logic           id_valid;
    logic           rfr;
    logic           tv, tr, tl;
    logic [3:0]     outstanding;
    logic [2:0]     last_grant;
    logic [31:0]    pkt_count;
    logic           err;
    logic           idle;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_held;
    logic [W-1:0] m_id;
    int          m_out;
    int          m_last;
    logic [31:0] m_pkt;
    bit          m_err;

    always #5 clk = ~clk;

    req_scheduler #(
        .REQ_ID_WIDTH   (W),
        .NUM_REQ        (N),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ENABLE       (enable),
        .REQ_ID_IN    (req_id_in),
        .REQ_VALID_IN (req_valid),
        .REQ_READY_OUT(ready_out),
        .REQ_ID_OUT   (id_out),
        .REQ_ID_VALID (id_valid),
        .READY_FOR_REQ(rfr),
        .TX_TVALID    (tv),
        .TX_TREADY    (tr),
        .TX_TLAST     (tl),
        .OUTSTANDING  (outstanding),
        .LAST_GRANT   (last_grant),
        .PKT_COUNT    (pkt_count),
        .ERR_UNDERFLOW(err),
        .IDLE         (idle)
    );

    // Which requester the rules say is accepted right now (one-hot, or zero).
    function automatic logic [N-1:0] model_ready();
        if (reset || !enable || m_held || m_out >= MAXO) return '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (req_valid[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    // Advance the model with the current inputs, then step past the clock edge.
    task automatic cycle();
        logic [N-1:0] r;
        bit issue, foot;
        r    = model_ready();
        issue = m_held && rfr;
        foot = tv && tr && tl;
        if (reset) begin
            m_held = 0; m_id = '0; m_out = 0; m_last = N - 1; m_pkt = '0; m_err = 0;
        end else begin
            if (issue) m_held = 0;
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    m_held = 1;
                    m_id   = req_id_in[i*W +: W];
                    m_last = i;
                end
            end
            if (issue && !foot) m_out++;
            else if (foot && !issue) begin
                if (m_out == 0) m_err = 1;
                else m_out--;
            end
            if (foot) m_pkt = m_pkt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; enable = 0; req_valid = '0; rfr = 0; tv = 0; tr = 0; tl = 0;
        cycle();
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable = 1; req_valid = '1; rfr = 1;
        cycle();
        cycle();
        #1;
        vectors++; if (ready_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready got=%b exp=0000", ready_out); end
        vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_id_valid got=%b exp=0", id_valid); end
        vectors++; if (id_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_id_out got=%h exp=0", id_out); end
        vectors++; if (outstanding !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_outstanding got=%0d exp=0", outstanding); end
        vectors++; if (last_grant !== 3'd3) begin miscompares++; $display("[TB] FAIL reset_last_grant got=%0d exp=3", last_grant); end
        vectors++; if (pkt_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err got=%b exp=0", err); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_idle got=%b exp=1", idle); end
        reset = 0; req_valid = '0; rfr = 0;
    endtask

    task automatic test_single();
        do_reset();
        enable = 1; rfr = 1;
        req_id_in[2*W +: W] = 32'h55;
        req_valid = 4'b0100;
        #1;
        vectors++; if (ready_out !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_ready got=%b exp=0100", ready_out); end
        cycle();
        req_valid = '0;
        #1;
        vectors++; if (ready_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_ready_once got=%b exp=0000", ready_out); end
        vectors++; if (id_out !== 32'h55 || id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_offer got=%h/%b exp=55/1", id_out, id_valid); end
        vectors++; if (last_grant !== 3'd2) begin miscompares++; $display("[TB] FAIL single_last_grant got=%0d exp=2", last_grant); end
        cycle();
        vectors++; if (outstanding !== 4'd1 || id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_issue got=%0d/%b exp=1/0", outstanding, id_valid); end
    endtask

    task automatic test_round_robin();
        int got;
        do_reset();
        enable = 1; rfr = 1;
        for (int i = 0; i < N; i++) req_id_in[i*W +: W] = 32'h10 + 32'(i);
        req_valid = '1;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            tv = (m_out > 0); tr = tv; tl = tv;
            #1;
            if (id_valid) begin
                vectors++; if (id_out !== 32'h10 + 32'(got % 4)) begin miscompares++; $display("[TB] FAIL rr_order n=%0d got=%h exp=%h", got, id_out, 32'h10 + 32'(got % 4)); end
                vectors++; if (last_grant !== 3'(got % 4)) begin miscompares++; $display("[TB] FAIL rr_last_grant n=%0d got=%0d exp=%0d", got, last_grant, got % 4); end
                got++;
            end
            cycle();
        end
        vectors++; if (got < 5) begin miscompares++; $display("[TB] FAIL rr_timeout got=%0d exp=5 issues", got); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_err got=%b exp=0", err); end
        req_valid = '0; tv = 0; tr = 0; tl = 0;
    endtask

    task automatic test_max_outstanding();
        int grants;
        do_reset();
        enable = 1; rfr = 1;
        req_id_in[0 +: W] = 32'h77;
        req_valid = 4'b0001;
        grants = 0;
        repeat (12) begin
            #1;
            if (ready_out != '0) grants++;
            cycle();
        end
        vectors++; if (grants != 2) begin miscompares++; $display("[TB] FAIL max_grants got=%0d exp=2", grants); end
        vectors++; if (outstanding !== 4'd2) begin miscompares++; $display("[TB] FAIL max_outstanding got=%0d exp=2", outstanding); end
        tv = 1; tr = 1; tl = 1;
        #1;
        vectors++; if (ready_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL max_blocked got=%b exp=0000", ready_out); end
        cycle();
        tv = 0; tr = 0; tl = 0;
        #1;
        vectors++; if (ready_out !== 4'b0001) begin miscompares++; $display("[TB] FAIL max_third got=%b exp=0001", ready_out); end
        vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("[TB] FAIL max_pkt got=%0d exp=1", pkt_count); end
        cycle();
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        enable = 1; rfr = 0;
        req_id_in[1*W +: W] = 32'hABCD0001;
        req_valid = 4'b0010;
        cycle();
        for (int c = 0; c < 10; c++) begin
            req_id_in[1*W +: W] = $urandom;
            #1;
            vectors++; if (id_out !== 32'hABCD0001 || id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_hold c=%0d got=%h/%b exp=abcd0001/1", c, id_out, id_valid); end
            vectors++; if (ready_out !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_ready c=%0d got=%b exp=0000", c, ready_out); end
            cycle();
        end
        req_valid = '0; rfr = 1;
        cycle();
        vectors++; if (id_valid !== 1'b0 || outstanding !== 4'd1) begin miscompares++; $display("[TB] FAIL bp_release got=%b/%0d exp=0/1", id_valid, outstanding); end
        cycle();
        vectors++; if (outstanding !== 4'd1) begin miscompares++; $display("[TB] FAIL bp_single got=%0d exp=1", outstanding); end
        rfr = 0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        enable = 1; rfr = 1;
        req_id_in[0 +: W] = 32'h31;
        req_valid = 4'b0001;
        cycle();
        cycle();
        cycle();
        req_valid = '0; tv = 1; tr = 1; tl = 1;
        #1;
        vectors++; if (id_valid !== 1'b1 || outstanding !== 4'd1) begin miscompares++; $display("[TB] FAIL simul_setup got=%b/%0d exp=1/1", id_valid, outstanding); end
        cycle();
        tv = 0; tr = 0; tl = 0;
        vectors++; if (outstanding !== 4'd1) begin miscompares++; $display("[TB] FAIL simul_outstanding got=%0d exp=1", outstanding); end
        vectors++; if (pkt_count !== 32'd1 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL simul_pkt got=%0d/%b exp=1/0", pkt_count, err); end
    endtask

    task automatic test_underflow_and_reset();
        do_reset();
        tv = 1; tr = 1; tl = 1;
        cycle();
        tv = 0; tr = 0; tl = 0;
        vectors++; if (err !== 1'b1 || outstanding !== 4'd0) begin miscompares++; $display("[TB] FAIL uf_set got=%b/%0d exp=1/0", err, outstanding); end
        vectors++; if (pkt_count !== 32'd1) begin miscompares++; $display("[TB] FAIL uf_pkt got=%0d exp=1", pkt_count); end
        repeat (3) cycle();
        vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_sticky got=%b exp=1", err); end
        enable = 1; rfr = 0;
        req_id_in[2*W +: W] = 32'h99;
        req_valid = 4'b0100;
        cycle();
        req_valid = '0;
        vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_offer_setup got=%b exp=1", id_valid); end
        reset = 1;
        cycle();
        reset = 0;
        vectors++; if (id_valid !== 1'b0 || outstanding !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_offer got=%b/%0d exp=0/0", id_valid, outstanding); end
        vectors++; if (pkt_count !== 32'd0 || err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_counters got=%0d/%b exp=0/0", pkt_count, err); end
        vectors++; if (last_grant !== 3'd3 || idle !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_state got=%0d/%b exp=3/1", last_grant, idle); end
        enable = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset     = ($urandom_range(63) == 0);
            enable    = ($urandom_range(3) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) req_id_in[i*W +: W] = $urandom;
            rfr = ($urandom_range(1) == 1);
            tv  = ($urandom_range(2) != 0);
            tr  = ($urandom_range(2) != 0);
            tl  = ($urandom_range(1) == 1);
            #2;
            vectors++; if (ready_out !== model_ready()) begin miscompares++; $display("[TB] FAIL rnd_ready c=%0d got=%b exp=%b", c, ready_out, model_ready()); end
            vectors++; if (id_valid !== m_held) begin miscompares++; $display("[TB] FAIL rnd_id_valid c=%0d got=%b exp=%b", c, id_valid, m_held); end
            vectors++; if (id_out !== m_id) begin miscompares++; $display("[TB] FAIL rnd_id_out c=%0d got=%h exp=%h", c, id_out, m_id); end
            vectors++; if (outstanding !== 4'(m_out)) begin miscompares++; $display("[TB] FAIL rnd_outstanding c=%0d got=%0d exp=%0d", c, outstanding, m_out); end
            vectors++; if (last_grant !== 3'(m_last)) begin miscompares++; $display("[TB] FAIL rnd_last_grant c=%0d got=%0d exp=%0d", c, last_grant, m_last); end
            vectors++; if (pkt_count !== m_pkt) begin miscompares++; $display("[TB] FAIL rnd_pkt c=%0d got=%0d exp=%0d", c, pkt_count, m_pkt); end
            vectors++; if (err !== m_err) begin miscompares++; $display("[TB] FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); end
            vectors++; if (idle !== (!m_held && m_out == 0)) begin miscompares++; $display("[TB] FAIL rnd_idle c=%0d got=%b exp=%b", c, idle, (!m_held && m_out == 0)); end
            cycle();
        end
        reset = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1; enable = 0; req_id_in = '0; req_valid = '0; rfr = 0;
        tv = 0; tr = 0; tl = 0;
        m_held = 0; m_id = '0; m_out = 0; m_last = N - 1; m_pkt = '0; m_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_max_outstanding();
        test_backpressure();
        test_simultaneous();
        test_underflow_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
